// File: rtl/info_panel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : info_panel_ctrl
// Description : Redraws up to five status items into the framebuffer through
//               a 2-cycle-latency glyph renderer, one arbitrated row at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module info_panel_ctrl #(
    parameter int          FB_STRIDE  = 320,
    parameter int          ORIGIN_X   = 8,
    parameter int          ORIGIN_Y   = 4,
    parameter int          ITEM_PITCH = 28,
    parameter logic [7:0]  TRANSP     = 8'hFF
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  item_mask,
    input  logic [4:0]  val_round,
    input  logic [4:0]  val_time,
    input  logic [4:0]  val_buff,
    input  logic [4:0]  val_hp,
    input  logic [4:0]  val_shield,
    output logic [7:0]  x_pos,
    output logic [4:0]  y_pos,
    output logic [2:0]  info_type,
    output logic [4:0]  num,
    input  logic [7:0]  pix_data,
    output logic        fb_req,
    input  logic        fb_gnt,
    output logic        fb_we,
    output logic [16:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_req   = 3'd1;
    localparam logic [2:0] c_st_row   = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_next  = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    localparam logic [4:0] c_max_val  = 5'd29;
    localparam logic [4:0] c_last_row = 5'd23;

    logic [2:0]  r_state;
    logic [4:0]  r_mask;
    logic [4:0]  r_val0, r_val1, r_val2, r_val3, r_val4;
    logic [2:0]  r_item;
    logic [4:0]  r_y;
    logic        r_drain;

    // Two-stage write pipeline aligned to the renderer latency
    logic [7:0]  r_x1;
    logic [4:0]  r_y1;
    logic [2:0]  r_item1;
    logic        r_v1;
    logic        r_v2;
    logic [16:0] r_addr2;

    logic [3:0]  w_first;
    logic [3:0]  w_next;
    logic [4:0]  w_cur_val;
    logic [7:0]  w_last_x;
    logic [16:0] w_addr;

    // Lowest enabled item index >= from; bit 3 flags that one exists
    function automatic logic [3:0] f_pick(input logic [4:0] mask, input logic [2:0] from);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 4; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from)))
                res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    function automatic logic [4:0] f_clamp(input logic [4:0] v);
        return (v > c_max_val) ? c_max_val : v;
    endfunction

    assign w_first = f_pick(item_mask, 3'd0);
    assign w_next  = f_pick(r_mask, r_item + 3'd1);

    always_comb begin
        w_cur_val = 5'd0;
        w_last_x  = 8'd0;
        case (r_item)
            3'd0:    begin w_cur_val = r_val0; w_last_x = 8'd133; end
            3'd1:    begin w_cur_val = r_val1; w_last_x = 8'd105; end
            3'd2:    begin w_cur_val = r_val2; w_last_x = 8'd105; end
            3'd3:    begin w_cur_val = r_val3; w_last_x = 8'd77;  end
            3'd4:    begin w_cur_val = r_val4; w_last_x = 8'd126; end
            default: begin w_cur_val = 5'd0;   w_last_x = 8'd0;   end
        endcase
    end

    assign w_addr = (17'(ORIGIN_Y) + 17'(r_item1) * 17'(ITEM_PITCH) + 17'(r_y1)) * 17'(FB_STRIDE)
                  + 17'(ORIGIN_X) + 17'(r_x1);

    assign fb_req  = (r_state == c_st_req) || (r_state == c_st_row) || (r_state == c_st_drain);
    assign busy    = (r_state != c_st_idle);
    assign done    = (r_state == c_st_done);
    assign fb_we   = r_v2 && (pix_data != TRANSP);
    assign fb_data = r_v2 ? pix_data : 8'h00;
    assign fb_addr = r_addr2;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_mask    <= 5'd0;
            r_val0    <= 5'd0;
            r_val1    <= 5'd0;
            r_val2    <= 5'd0;
            r_val3    <= 5'd0;
            r_val4    <= 5'd0;
            r_item    <= 3'd0;
            r_y       <= 5'd0;
            r_drain   <= 1'b0;
            x_pos     <= 8'd0;
            y_pos     <= 5'd0;
            info_type <= 3'd0;
            num       <= 5'd0;
            r_x1      <= 8'd0;
            r_y1      <= 5'd0;
            r_item1   <= 3'd0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_addr2   <= 17'd0;
        end else begin
            r_x1    <= x_pos;
            r_y1    <= y_pos;
            r_item1 <= info_type;
            r_v1    <= (r_state == c_st_row);
            r_v2    <= r_v1;
            if (r_v1)
                r_addr2 <= w_addr;

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_mask  <= item_mask;
                        r_val0  <= f_clamp(val_round);
                        r_val1  <= f_clamp(val_time);
                        r_val2  <= f_clamp(val_buff);
                        r_val3  <= f_clamp(val_hp);
                        r_val4  <= f_clamp(val_shield);
                        r_y     <= 5'd0;
                        r_item  <= w_first[2:0];
                        r_state <= w_first[3] ? c_st_req : c_st_done;
                    end
                end
                c_st_req: begin
                    if (fb_gnt) begin
                        x_pos     <= 8'd0;
                        y_pos     <= r_y;
                        info_type <= r_item;
                        num       <= w_cur_val;
                        r_state   <= c_st_row;
                    end
                end
                c_st_row: begin
                    if (x_pos == w_last_x) begin
                        r_drain <= 1'b0;
                        r_state <= c_st_drain;
                    end else begin
                        x_pos <= x_pos + 8'd1;
                    end
                end
                c_st_drain: begin
                    if (r_drain)
                        r_state <= c_st_next;
                    else
                        r_drain <= 1'b1;
                end
                c_st_next: begin
                    if (r_y == c_last_row) begin
                        r_y <= 5'd0;
                        if (w_next[3]) begin
                            r_item  <= w_next[2:0];
                            r_state <= c_st_req;
                        end else begin
                            r_state <= c_st_done;
                        end
                    end else begin
                        r_y     <= r_y + 5'd1;
                        r_state <= c_st_req;
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
